// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control path: opcodes, ALUOp and
// datapath select encodings, and the main FSM state enumeration.
// Optional feature macro: RISCV_JAL_EN adds the S_JAL state.
package riscv_pkg;

  // Major opcodes, IR[6:0]
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALUOp encodings shared with the ALU control block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Register write-back source select
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam int unsigned STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
`ifdef RISCV_JAL_EN
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11
`else
    S_BRANCH   = 4'd10
`endif
  } state_e;

endpackage

// File: rtl/riscv_multicycle_control.sv
// Main control FSM of the multicycle RISC-V datapath. Sequences fetch, decode,
// execute, memory and write-back, stalls on MemReady and counts retired
// instructions. Define RISCV_JAL_EN to add jal support (S_JAL).
module riscv_multicycle_control
  import riscv_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [6:0]         Opcode,
  input  logic               MemReady,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               Branch,
  output logic               PCSource,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               IllegalOp,
  output logic [CNT_W-1:0]   InstrCount,
  output logic [STATE_W-1:0] State
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             illegal;
  logic             retire;

  // Next-state selection and illegal-opcode detection
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        if (Opcode == OP_LOAD || Opcode == OP_STORE) state_d = S_MEMADR;
        else if (Opcode == OP_RTYPE)                 state_d = S_EXECR;
        else if (Opcode == OP_ITYPE)                 state_d = S_EXECI;
        else if (Opcode == OP_BRANCH)                state_d = S_BRANCH;
`ifdef RISCV_JAL_EN
        else if (Opcode == OP_JAL)                   state_d = S_JAL;
`endif
        else begin
          state_d = S_FETCH;
          illegal = 1'b1;
        end
      end
      // IR is only written in S_FETCH, so Opcode is still the decoded one here
      S_MEMADR:   state_d = (Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
`ifdef RISCV_JAL_EN
      S_JAL:      state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires when a completing state hands back to fetch
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: retire = 1'b1;
`ifdef RISCV_JAL_EN
        S_JAL:                                  retire = 1'b1;
`endif
        default:                                retire = 1'b0;
      endcase
    end
  end

  // State register and retired-instruction counter; reset drops any access
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_RESET;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  // Datapath control decode from the current state (fetch enables wait on MemReady)
  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    PCSource  = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    MemtoReg  = WB_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    IllegalOp = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        IllegalOp = illegal;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = WB_MDR;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
      end
      // addi only: plain add so imm[11:5] never reaches funct7 decode
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        MemtoReg = WB_ALUOUT;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_RS2;
        ALUOp    = ALUOP_SUB;
        Branch   = 1'b1;
        PCSource = 1'b1;
      end
`ifdef RISCV_JAL_EN
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = WB_PC;
      end
`endif
      default: ;
    endcase
  end

  assign InstrCount = count_q;
  assign State      = STATE_W'(state_q);

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Self-checking bench for riscv_multicycle_control. Each instruction is expanded
// into a list of expected cycles (with random memory stalls) and every cycle's
// controls, state and retired count are compared. A 4-bit counter exercises wrap.
module tb_riscv_multicycle_control;
  import riscv_pkg::*;

  localparam int CW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [6:0]    Opcode = 7'd0;
  logic          MemReady = 1'b0;
  logic          IRWrite, PCWrite, Branch, PCSource, IorD, MemRead, MemWrite, RegWrite;
  logic [1:0]    MemtoReg, ALUSrcA, ALUSrcB, ALUOp;
  logic          IllegalOp;
  logic [CW-1:0] InstrCount;
  logic [3:0]    State;

  riscv_multicycle_control #(.CNT_W(CW), .STATE_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .IllegalOp(IllegalOp), .InstrCount(InstrCount), .State(State)
  );

  always #5 Clock = ~Clock;

  typedef enum int {
    PhReset, PhFetchWait, PhFetchGo, PhDecode, PhDecodeBad, PhAdr, PhRdWait, PhRdGo,
    PhLoadWb, PhWrWait, PhWrGo, PhExecR, PhExecI, PhAluWb, PhBranch, PhJal
  } phase_e;

  typedef struct packed {
    logic       ir_write, pc_write, branch, pc_source, iord, mem_read, mem_write, reg_write;
    logic [1:0] memto_reg, src_a, src_b, alu_op;
    logic       illegal;
  } ctrl_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cycle    = 0;
  logic [CW-1:0] exp_count = '0;
  phase_e        ph_q[$];
  int            rdy_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, got, exp);
    end
  endtask

  // Expected control word for each cycle kind, written straight from the control table
  function automatic ctrl_t exp_ctrl(input phase_e ph);
    ctrl_t c = '0;
    case (ph)
      PhFetchWait: begin c.mem_read = 1; c.src_b = 2'b01; end
      PhFetchGo: begin
        c.mem_read = 1; c.src_b = 2'b01; c.ir_write = 1; c.pc_write = 1;
      end
      PhDecode:    begin c.src_a = 2'b01; c.src_b = 2'b10; end
      PhDecodeBad: begin c.src_a = 2'b01; c.src_b = 2'b10; c.illegal = 1; end
      PhAdr:       begin c.src_a = 2'b10; c.src_b = 2'b10; end
      PhRdWait, PhRdGo: begin c.mem_read = 1; c.iord = 1; end
      PhLoadWb:    begin c.reg_write = 1; c.memto_reg = 2'b01; end
      PhWrWait, PhWrGo: begin c.mem_write = 1; c.iord = 1; end
      PhExecR:     begin c.src_a = 2'b10; c.alu_op = 2'b10; end
      PhExecI:     begin c.src_a = 2'b10; c.src_b = 2'b10; end
      PhAluWb:     c.reg_write = 1;
      PhBranch: begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1; c.pc_source = 1; end
      PhJal: begin
        c.pc_write = 1; c.pc_source = 1; c.reg_write = 1; c.memto_reg = 2'b10;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] exp_state(input phase_e ph);
    case (ph)
      PhFetchWait, PhFetchGo: return S_FETCH;
      PhDecode, PhDecodeBad:  return S_DECODE;
      PhAdr:                  return S_MEMADR;
      PhRdWait, PhRdGo:       return S_MEMREAD;
      PhLoadWb:               return S_MEMWB;
      PhWrWait, PhWrGo:       return S_MEMWRITE;
      PhExecR:                return S_EXECR;
      PhExecI:                return S_EXECI;
      PhAluWb:                return S_ALUWB;
      PhBranch:               return S_BRANCH;
`ifdef RISCV_JAL_EN
      PhJal:                  return S_JAL;
`endif
      default:                return S_RESET;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
`ifdef RISCV_JAL_EN
    if (op == 7'b1101111) return 1;
`endif
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011;
  endfunction

  // rdy < 0 means MemReady is a don't-care this cycle and is randomised
  task automatic add(input phase_e ph, input int rdy);
    ph_q.push_back(ph);
    rdy_q.push_back(rdy);
  endtask

  task automatic play(input logic [6:0] op);
    while (ph_q.size() > 0) begin
      phase_e ph  = ph_q.pop_front();
      int     rdy = rdy_q.pop_front();
      Opcode   = op;
      MemReady = (rdy < 0) ? 1'($urandom % 2) : 1'(rdy);
      @(negedge Clock);
      check("ctrl", 32'({IRWrite, PCWrite, Branch, PCSource, IorD, MemRead, MemWrite,
                         RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, IllegalOp}),
            32'(exp_ctrl(ph)));
      check("state", 32'(State), 32'(exp_state(ph)));
      check("count", 32'(InstrCount), 32'(exp_count));
      @(posedge Clock);
      #1;
      cycle++;
    end
  endtask

  // One instruction: fetch with fs stall cycles, memory access with ms stall cycles
  task automatic run_instr(input logic [6:0] op, input int fs, input int ms);
    bit retires = 1;
    repeat (fs) add(PhFetchWait, 0);
    add(PhFetchGo, 1);
    if (!is_legal(op)) begin
      add(PhDecodeBad, -1);
      retires = 0;
    end else begin
      add(PhDecode, -1);
      if (op == 7'b0000011) begin
        add(PhAdr, -1);
        repeat (ms) add(PhRdWait, 0);
        add(PhRdGo, 1);
        add(PhLoadWb, -1);
      end else if (op == 7'b0100011) begin
        add(PhAdr, -1);
        repeat (ms) add(PhWrWait, 0);
        add(PhWrGo, 1);
      end else if (op == 7'b0110011) begin
        add(PhExecR, -1); add(PhAluWb, -1);
      end else if (op == 7'b0010011) begin
        add(PhExecI, -1); add(PhAluWb, -1);
      end else if (op == 7'b1100011) begin
        add(PhBranch, -1);
      end else begin
        add(PhJal, -1);
      end
    end
    play(op);
    if (retires) exp_count = exp_count + 1'b1;
  endtask

  logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                         7'b1101111};

  initial begin
    // Two reset cycles: held in S_RESET with everything low
    repeat (2) begin
      @(posedge Clock); #1;
      @(negedge Clock);
      check("rst_ctrl", 32'({IRWrite, PCWrite, Branch, PCSource, IorD, MemRead, MemWrite,
                             RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, IllegalOp}), 0);
      check("rst_state", 32'(State), 32'(S_RESET));
      check("rst_count", 32'(InstrCount), 0);
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
    add(PhReset, -1);
    play(7'd0);

    // Directed cases
    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0000011, 2, 2);
    run_instr(7'b0100011, 0, 0);
    run_instr(7'b1100011, 0, 0);
    run_instr(7'b1111111, 0, 0);
    run_instr(7'b1101111, 0, 0);
    run_instr(7'b0010011, 1, 0);

    // Random mix; counter wraps more than once
    for (int i = 0; i < 80; i++) begin
      logic [6:0] op;
      if ($urandom % 6 == 0) op = 7'($urandom);
      else op = ops[$urandom % 6];
      run_instr(op, int'($urandom % 3), int'($urandom % 3));
    end

    // Reset arriving mid load while memory is stalled
    add(PhFetchGo, 1); add(PhDecode, -1); add(PhAdr, -1);
    play(7'b0000011);
    Reset = 1'b1;
    add(PhRdWait, 0);
    play(7'b0000011);
    exp_count = '0;
    @(negedge Clock);
    check("midrst_ctrl", 32'({IRWrite, PCWrite, Branch, PCSource, IorD, MemRead, MemWrite,
                              RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, IllegalOp}), 0);
    check("midrst_state", 32'(State), 32'(S_RESET));
    check("midrst_count", 32'(InstrCount), 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    add(PhReset, -1);
    play(7'd0);
    run_instr(7'b0110011, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
